// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: operation codes, FSM states and
// small op-classification helpers used by the top and the mul/div unit.
package alu_pkg;

    // Encodings are dense from 0 to OP_REMU; anything above is unknown.
    typedef enum logic [4:0] {
        OP_AND  = 5'd0,
        OP_OR   = 5'd1,
        OP_ADD  = 5'd2,
        OP_SUB  = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_ADDR = 5'd10,
        OP_BEQ  = 5'd11,
        OP_BNE  = 5'd12,
        OP_BLT  = 5'd13,
        OP_BGE  = 5'd14,
        OP_BLTU = 5'd15,
        OP_BGEU = 5'd16,
        OP_MUL  = 5'd17,
        OP_DIV  = 5'd18,
        OP_DIVU = 5'd19,
        OP_REM  = 5'd20,
        OP_REMU = 5'd21
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } alu_state_t;

    function automatic logic is_muldiv(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
               (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_branch(input alu_op_t op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
               (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Start/done request bus between the controller (master) and the ALU (slave).
interface alu_mc_if #(parameter int XLEN = 32) ();
    import alu_pkg::*;

    logic            start;
    alu_op_t         op;
    logic            alusrc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] immediate;
    logic            branch;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            taken;
    logic            pcsrc;
    logic            illegal;

    modport master (
        output start, op, alusrc, rs1_data, rs2_data, immediate, branch,
        input  busy, done, result, taken, pcsrc, illegal
    );

    modport slave (
        input  start, op, alusrc, rs1_data, rs2_data, immediate, branch,
        output busy, done, result, taken, pcsrc, illegal
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle for XLEN cycles. Signs are restored on the
// output so the parent can register the final value in its FIN state.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_go,
    input  alu_op_t         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_out,
    output logic            o_fin
);

    localparam int CNTW = $clog2(XLEN);

    // r_acc is the product (MUL) or partial remainder (DIV);
    // r_lo is the multiplier shifting right (MUL) or dividend turning into
    // quotient while shifting left (DIV); r_opB is the multiplicand shifting
    // left (MUL) or the constant divisor magnitude (DIV).
    alu_op_t         r_op;
    logic            r_isMul;
    logic            r_running;
    logic [CNTW-1:0] r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opB;
    logic            r_aNeg;
    logic            r_bNeg;
    logic            r_bZero;

    logic            w_signed;
    logic            w_aNeg;
    logic            w_bNeg;
    logic [XLEN-1:0] w_aMag;
    logic [XLEN-1:0] w_bMag;
    logic [XLEN:0]   w_remShift;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_quotFix;
    logic [XLEN-1:0] w_remFix;

    assign w_signed   = (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_aNeg     = w_signed & i_a[XLEN-1];
    assign w_bNeg     = w_signed & i_b[XLEN-1];
    assign w_aMag     = w_aNeg ? -i_a : i_a;
    assign w_bMag     = w_bNeg ? -i_b : i_b;
    assign w_remShift = {r_acc, r_lo[XLEN-1]};
    assign w_trial    = w_remShift - {1'b0, r_opB};
    assign o_fin      = r_running && (r_cnt == CNTW'(XLEN - 1));

    // Load operands on go, then advance one multiply or divide step per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op      <= OP_MUL;
            r_isMul   <= 1'b0;
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_opB     <= '0;
            r_aNeg    <= 1'b0;
            r_bNeg    <= 1'b0;
            r_bZero   <= 1'b0;
        end else if (i_go) begin
            r_op      <= i_op;
            r_isMul   <= (i_op == OP_MUL);
            r_running <= 1'b1;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_lo      <= (i_op == OP_MUL) ? i_b : w_aMag;
            r_opB     <= (i_op == OP_MUL) ? i_a : w_bMag;
            r_aNeg    <= w_aNeg;
            r_bNeg    <= w_bNeg;
            r_bZero   <= (i_b == '0);
        end else if (r_running) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_fin) begin
                r_running <= 1'b0;
            end
            if (r_isMul) begin
                if (r_lo[0]) begin
                    r_acc <= r_acc + r_opB;
                end
                r_opB <= r_opB << 1;
                r_lo  <= r_lo >> 1;
            end else if (!w_trial[XLEN]) begin
                r_acc <= w_trial[XLEN-1:0];
                r_lo  <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
                r_acc <= w_remShift[XLEN-1:0];
                r_lo  <= {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign w_quotFix = (r_aNeg ^ r_bNeg) ? -r_lo : r_lo;
    assign w_remFix  = r_aNeg ? -r_acc : r_acc;

    // Select the signed-corrected answer; divide by zero yields all ones,
    // while remainder by zero falls out naturally as the dividend.
    always_comb begin
        o_out = r_acc;
        case (r_op)
            OP_MUL:          o_out = r_acc;
            OP_DIV, OP_DIVU: o_out = r_bZero ? '1 : w_quotFix;
            OP_REM, OP_REMU: o_out = w_remFix;
            default:         o_out = r_acc;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multicycle RISC-V ALU. A start/done handshake latches operands, single-cycle
// ops finish via FIN, and M-extension ops iterate in the mul/div unit first.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit MULDIV_EN  = 1'b1,
    parameter int ADDR_SHIFT = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);

    localparam int SHW = $clog2(XLEN);

    alu_state_t      r_state;
    alu_state_t      w_nextState;
    alu_op_t         r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_taken;
    logic            r_illegal;
    logic            r_done;

    logic [XLEN-1:0] w_bOperand;
    logic            w_accept;
    logic            w_useIter;
    logic            w_mdGo;
    logic [XLEN-1:0] w_mdOut;
    logic            w_mdFin;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_aluResult;
    logic            w_aluTaken;
    logic            w_known;

    assign w_bOperand = bus.alusrc ? bus.immediate : bus.rs2_data;
    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_useIter  = MULDIV_EN && is_muldiv(bus.op);
    assign w_mdGo     = w_accept && w_useIter;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: iterate only for enabled M ops, everything else goes to FIN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_nextState = w_useIter ? ST_CALC : ST_FIN;
            ST_CALC: if (w_mdFin)   w_nextState = ST_FIN;
            ST_FIN:                 w_nextState = ST_IDLE;
            default:                w_nextState = ST_IDLE;
        endcase
    end

    // Capture op and operands when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= OP_AND;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= bus.op;
            r_a  <= bus.rs1_data;
            r_b  <= w_bOperand;
        end
    end

    assign w_sum   = r_a + r_b;
    assign w_diff  = r_a - r_b;
    assign w_shamt = r_b[SHW-1:0];

    // Single-cycle results and branch conditions from the latched operands.
    always_comb begin
        w_aluResult = '0;
        w_aluTaken  = 1'b0;
        w_known     = 1'b1;
        case (r_op)
            OP_AND:  w_aluResult = r_a & r_b;
            OP_OR:   w_aluResult = r_a | r_b;
            OP_XOR:  w_aluResult = r_a ^ r_b;
            OP_ADD:  w_aluResult = w_sum;
            OP_SUB:  w_aluResult = w_diff;
            OP_SLL:  w_aluResult = r_a << w_shamt;
            OP_SRL:  w_aluResult = r_a >> w_shamt;
            OP_SRA:  w_aluResult = $signed(r_a) >>> w_shamt;
            OP_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(r_b)};
            OP_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, r_a < r_b};
            OP_ADDR: w_aluResult = $signed(w_sum) >>> ADDR_SHIFT;
            OP_BEQ:  begin w_aluResult = w_diff; w_aluTaken = (r_a == r_b); end
            OP_BNE:  begin w_aluResult = w_diff; w_aluTaken = (r_a != r_b); end
            OP_BLT:  begin w_aluResult = w_diff; w_aluTaken = $signed(r_a) < $signed(r_b); end
            OP_BGE:  begin w_aluResult = w_diff; w_aluTaken = $signed(r_a) >= $signed(r_b); end
            OP_BLTU: begin w_aluResult = w_diff; w_aluTaken = r_a < r_b; end
            OP_BGEU: begin w_aluResult = w_diff; w_aluTaken = r_a >= r_b; end
            OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_known = MULDIV_EN;
            default: w_known = 1'b0;
        endcase
    end

    generate
        if (MULDIV_EN) begin : g_muldiv
            alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_go    (w_mdGo),
                .i_op    (bus.op),
                .i_a     (bus.rs1_data),
                .i_b     (w_bOperand),
                .o_out   (w_mdOut),
                .o_fin   (w_mdFin)
            );
        end else begin : g_nomuldiv
            assign w_mdOut = '0;
            assign w_mdFin = 1'b0;
        end
    endgenerate

    // Register the outcome in FIN and pulse done as the FSM returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
            if (r_state == ST_FIN) begin
                if (!w_known) begin
                    r_result  <= '0;
                    r_taken   <= 1'b0;
                    r_illegal <= 1'b1;
                end else if (is_muldiv(r_op)) begin
                    r_result  <= w_mdOut;
                    r_taken   <= 1'b0;
                    r_illegal <= 1'b0;
                end else begin
                    r_result  <= w_aluResult;
                    r_taken   <= w_aluTaken;
                    r_illegal <= 1'b0;
                end
            end
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.taken   = r_taken;
    assign bus.illegal = r_illegal;
    assign bus.pcsrc   = r_taken & bus.branch;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multicycle ALU for the RISC-V datapath; successor to the single-cycle, state-gated ALU.
- Execution is triggered by a start/done handshake instead of decoding the controller state, and all operands are latched at start.
- Adds signed/unsigned compares, full branch-condition set, shift masking, word-address generation and an iterative RV32M multiply/divide unit.
- Sits between register-file/immediate outputs and the memory/writeback stages; the controller holds in EXECUTE until done.

Parameters:
- XLEN, 32, operand/result width (power of 2, >=8).
- MULDIV_EN, 1, 1 = MUL/DIV/REM ops implemented; 0 = they return illegal.
- ADDR_SHIFT, 2, right shift applied by OP_ADDR to turn byte addresses into word indices.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  5  operation code (alu_pkg::alu_op_t).
- alusrc  in  1  0: operand b = rs2_data; 1: operand b = immediate.
- rs1_data  in  XLEN  operand a.
- rs2_data  in  XLEN  register operand b.
- immediate  in  XLEN  sign-extended immediate; two's complement, no separate sign flag.
- branch  in  1  instruction is a conditional branch.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result/taken/illegal valid from this cycle.
- result  out  XLEN  registered result, held until next done.
- taken  out  1  registered branch-condition result, held until next done.
- pcsrc  out  1  combinational taken & branch.
- illegal  out  1  registered; set with done for an unknown/disabled op.

Behaviour:
- Reset, async on rst_n low: state IDLE; busy=0, done=0, result=0, taken=0, illegal=0. Reset during CALC aborts the operation with no done.
- States:
  - IDLE: start=1 latches op, a=rs1_data and b=(alusrc ? immediate : rs2_data).
    - Single-cycle op → FIN.
    - MUL/DIV op → CALC with busy=1.
  - CALC: runs XLEN iterations, one per cycle, then → FIN.
  - FIN: registers result/taken/illegal, pulses done for 1 cycle, clears busy, returns to IDLE.
- Latency (start-cycle edge to done high):
  - Single-cycle ops: 1 cycle.
  - MUL/DIV ops: XLEN+1 cycles.
  - Back-to-back operation: a new start is allowed in the cycle done is high, since the state is IDLE again.
- start while busy=1 is ignored; inputs are don't-care after the start cycle.
- Single-cycle ops (modulo 2^XLEN):
  - AND, OR, XOR, ADD, SUB.
  - SLL, SRL, SRA: shift amount = b[log2(XLEN)-1:0] only.
  - SLT (signed), SLTU: result = 0/1.
  - ADDR: (a+b) >>> ADDR_SHIFT, arithmetic shift.
- Branch ops: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU.
  - result = a-b; taken = condition.
  - For every non-branch op taken=0.
- MUL: low XLEN bits of a*b, shift-add.
- DIV/DIVU/REM/REMU: restoring division on magnitudes, signs fixed in FIN. RISC-V corner cases:
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - a=most-negative, b=-1 (signed): DIV → a; REM → 0.
- Unknown op, or MULDIV_EN=0 with an M op: result=0, taken=0, illegal=1, latency 1.
- pcsrc follows the held taken & current branch; not gated by done.

Decomposition:
- alu_pkg holds:
  - alu_op_t enum (5 bits), with all op encodings: AND, OR, ADD, SUB, XOR, SLL, SRL, SRA, SLT, SLTU, ADDR, BEQ, BNE, BLT, BGE, BLTU, BGEU, MUL, DIV, DIVU, REM, REMU.
  - State enum.
  - is_muldiv() and is_branch() functions.
- One sub-module, alu_muldiv_iter, generated only when MULDIV_EN=1:
  - Iterative multiply/divide datapath with its own XLEN-count counter.
  - Interface: go, op, a, b, out, fin.
  - alu_mc owns the handshake.

Test Plan:
- Reset mid-DIV: start DIV, assert rst_n=0 at cycle 5 → busy=0, done never pulses, result=0.
- ADD, alusrc=1, rs1=100, imm=0xFFFFFFFC → done after 1 cycle, result=96. ADDR, rs1=0x40, imm=-8 → result=0xE.
- BEQ/BLT/BLTU with a=0xFFFFFFFF, b=1, branch=1:
  - BEQ → taken=0, pcsrc=0.
  - BLT → taken=1.
  - BLTU → taken=0.
  - Then branch=0 → pcsrc=0.
- MUL 0xFFFFFFFF*3 → done exactly 33 cycles after start, result=0xFFFFFFFD. Extra start pulses while busy have no effect.
- DIV 7/0 → 0xFFFFFFFF. REM 7/0 → 7. DIV 0x80000000/-1 → 0x80000000. REM -7/2 → -1. DIVU 100/7 → 14.
- SRA 0x80000000 by b=0x21 → shift 1 → 0xC0000000. Unknown op 0x1F → illegal=1, result=0, done after 1 cycle.
